peaks_readout_buffer: RTL

Parametrised, double-banked snapshot buffer between the peak finder and the 8-bit host bus. Each valid peak frame (time counter, PEAKS frequencies, PEAKS amplitudes) is captured into a back bank, then published to a host-visible front bank.
- The host may lock the front bank, so a multi-byte read sees one coherent frame.
- Frames arriving while locked are held. Overwritten frames are counted.
- The block replaces ad-hoc address-range snapshot gating with an explicit lock/status/sequence register interface.

---
 rtl/peaks_readout_buffer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/peaks_readout_buffer.sv
// peaks_readout_buffer
//   Double-banked snapshot buffer between the peak finder and an 8-bit host bus.
//   Each valid peak frame is captured into a back bank. It is then published to a
//   host-visible front bank, unless the host has locked the front bank.
//   Frames that are overwritten in the back bank before they can be published
//   are counted in a saturating drop counter.
//
// Ports
//   clk, reset   : system clock, synchronous active-high reset
//   valid_in     : one-cycle strobe qualifying counter_in/freqs_in/amps_in
//   counter_in   : frame time counter
//   freqs_in     : peak i frequency at [i*FREQ_WIDTH +: FREQ_WIDTH]
//   amps_in      : peak i amplitude at [i*AMPL_WIDTH +: AMPL_WIDTH]
//   chipselect   : host access select
//   write        : host write strobe (only CTRL at T accepts writes)
//   address      : host byte address
//   writedata    : host write data
//   readdata     : registered read data, 1-cycle latency, holds when idle
//   frame_ready  : one-cycle pulse on each publish
//
// Handshake: valid_in has no ready. Every cycle with valid_in=1 delivers a
// frame, and the frame is always accepted into the back bank. The newest frame
// wins, and any unpublished older frame is dropped and counted.
//
// Host map (T = 2^ADDR_WIDTH-8)
//   0..                : front bank, each field zero-extended to whole bytes and
//                        stored big-endian (counter, then freqs, then amps)
//   T+0 CTRL           : bit0 lock (r/w), bit1 clear_drop (write-only)
//   T+1 STATUS         : {6'b0, pending, locked}
//   T+2 SEQ, T+3 DROP  : front sequence number, saturating drop count
//   T+4..T+7           : signature 2A 35 54 47
module peaks_readout_buffer #(
  parameter int PEAKS         = 6,
  parameter int FREQ_WIDTH    = 8,
  parameter int AMPL_WIDTH    = 24,
  parameter int COUNTER_WIDTH = 32,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [COUNTER_WIDTH-1:0]      counter_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0]   freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0]   amps_in,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [7:0]                    writedata,
  output logic [7:0]                    readdata,
  output logic                          frame_ready
);

  localparam int CB        = (COUNTER_WIDTH + 7) / 8;
  localparam int FB        = (FREQ_WIDTH + 7) / 8;
  localparam int AB        = (AMPL_WIDTH + 7) / 8;
  localparam int MAP_BYTES = CB + PEAKS * FB + PEAKS * AB;
  localparam int CTRL_BASE = (1 << ADDR_WIDTH) - 8;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(CTRL_BASE);

  // The front bank must not overlap the control region.
  if (MAP_BYTES > CTRL_BASE) begin : g_map_overflow
    $error("peaks_readout_buffer: front bank map (%0d bytes) overlaps control region at %0d",
           MAP_BYTES, CTRL_BASE);
  end

  // Banks
  logic [COUNTER_WIDTH-1:0]    back_counter, front_counter;
  logic [PEAKS*FREQ_WIDTH-1:0] back_freqs, front_freqs;
  logic [PEAKS*AMPL_WIDTH-1:0] back_amps, front_amps;

  // Control / status
  logic       pending;
  logic       locked;
  logic [7:0] seq;
  logic [7:0] drop;

  // Publish and drop decisions use register values from before the edge.
  // A lock write on the same edge therefore does not block this publish.
  logic publish;
  logic ctrl_write;
  logic clear_drop;
  logic drop_event;
  logic unused_wd_bits;

  assign publish        = pending && !locked;
  assign ctrl_write     = chipselect && write && (address == CTRL_ADDR);
  assign clear_drop     = ctrl_write && writedata[1];
  assign drop_event     = valid_in && pending && !publish;
  assign unused_wd_bits = ^writedata[7:2];

  // Byte image of the front bank
  logic [7:0]      img [MAP_BYTES];
  logic [CB*8-1:0] cnt_ext;
  logic [FB*8-1:0] f_ext;
  logic [AB*8-1:0] a_ext;

  always_comb begin
    cnt_ext = (CB*8)'(front_counter);
    f_ext   = '0;
    a_ext   = '0;
    for (int k = 0; k < MAP_BYTES; k++) img[k] = 8'h00;
    for (int j = 0; j < CB; j++) img[j] = cnt_ext[(CB-1-j)*8 +: 8];
    for (int i = 0; i < PEAKS; i++) begin
      f_ext = (FB*8)'(front_freqs[i*FREQ_WIDTH +: FREQ_WIDTH]);
      for (int j = 0; j < FB; j++) img[CB + i*FB + j] = f_ext[(FB-1-j)*8 +: 8];
      a_ext = (AB*8)'(front_amps[i*AMPL_WIDTH +: AMPL_WIDTH]);
      for (int j = 0; j < AB; j++) img[CB + PEAKS*FB + i*AB + j] = a_ext[(AB-1-j)*8 +: 8];
    end
  end

  // Read mux
  logic [7:0] rd_next;

  always_comb begin
    rd_next = 8'h00;
    if (address >= CTRL_ADDR) begin
      case (address[2:0])
        3'd0:    rd_next = {7'b0, locked};
        3'd1:    rd_next = {6'b0, pending, locked};
        3'd2:    rd_next = seq;
        3'd3:    rd_next = drop;
        3'd4:    rd_next = 8'h2A;
        3'd5:    rd_next = 8'h35;
        3'd6:    rd_next = 8'h54;
        default: rd_next = 8'h47;
      endcase
    end else begin
      for (int k = 0; k < MAP_BYTES; k++) begin
        if (address == ADDR_WIDTH'(k)) rd_next = img[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      back_counter  <= '0;
      back_freqs    <= '0;
      back_amps     <= '0;
      front_counter <= '0;
      front_freqs   <= '0;
      front_amps    <= '0;
      pending       <= 1'b0;
      locked        <= 1'b0;
      seq           <= 8'h00;
      drop          <= 8'h00;
      readdata      <= 8'h00;
      frame_ready   <= 1'b0;
    end else begin
      frame_ready <= publish;
      if (publish) begin
        front_counter <= back_counter;
        front_freqs   <= back_freqs;
        front_amps    <= back_amps;
        seq           <= seq + 8'd1;
      end
      if (valid_in) begin
        back_counter <= counter_in;
        back_freqs   <= freqs_in;
        back_amps    <= amps_in;
      end
      // A publish on the same edge as a new frame leaves pending set.
      pending <= valid_in || (pending && !publish);
      if (clear_drop) begin
        drop <= 8'h00;
      end else if (drop_event && (drop != 8'hFF)) begin
        drop <= drop + 8'd1;
      end
      if (ctrl_write) locked <= writedata[0];
      // Host writes leave readdata untouched.
      if (chipselect && !write) readdata <= rd_next;
    end
  end

endmodule
